// File: rtl/dsm_sweep_ctrl_if.sv
// Step-word stream from the sweep controller to the NCO; tdata/tvalid hold until tready.
interface dsm_sweep_ctrl_if #(
  parameter int STEP_WIDTH = 32
);
  logic [STEP_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dsm_sweep_ctrl.sv
// Linear NCO step sweep: start@N -> tvalid@N+1, each point held max(dwell,1) cycles after tready;
// tdata/tvalid hold under backpressure. Define DSM_SWEEP_LOOP_EN for a repeating sawtooth sweep.
module dsm_sweep_ctrl #(
  parameter int STEP_WIDTH  = 32,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [STEP_WIDTH-1:0]  cfg_start_step,
  input  logic [STEP_WIDTH-1:0]  cfg_stop_step,
  input  logic [STEP_WIDTH-1:0]  cfg_step_inc,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_dither,
  dsm_sweep_ctrl_if.master       m_axis_step,
  output logic                   dither_enable,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            point_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, DWELL, FINISH} state_t;
  state_t state, state_nxt;

  logic [STEP_WIDTH-1:0]  start_q, stop_q, inc_q;
  logic [STEP_WIDTH-1:0]  tdata_q, tdata_nxt, step_next;
  logic [DWELL_WIDTH-1:0] dwell_q, cnt_q, cnt_nxt;
  logic [15:0]            idx_q, idx_nxt;
  logic                   dither_q;
  logic                   load_cfg;
  logic                   last_point;
  logic [STEP_WIDTH:0]    sum;

  assign sum        = {1'b0, tdata_q} + {1'b0, inc_q};
  assign last_point = (tdata_q == stop_q) || (start_q >= stop_q) || (inc_q == '0);
  // a carry out of the add is an overshoot just like reaching stop
  assign step_next  = (sum[STEP_WIDTH] || (sum[STEP_WIDTH-1:0] >= stop_q)) ? stop_q
                                                                           : sum[STEP_WIDTH-1:0];
  assign load_cfg   = (state == IDLE) && start && !abort;

  always_ff @(posedge aclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tdata_nxt = tdata_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    case (state)
      IDLE: begin
        if (load_cfg) begin
          state_nxt = ISSUE;
          tdata_nxt = cfg_start_step;
          idx_nxt   = '0;
        end
      end
      ISSUE: begin
        if (m_axis_step.tready) begin
          state_nxt = DWELL;
          cnt_nxt   = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
        end
      end
      DWELL: begin
        if (cnt_q != DWELL_WIDTH'(1)) begin
          cnt_nxt = cnt_q - DWELL_WIDTH'(1);
        end else if (last_point) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = ISSUE;
          tdata_nxt = step_next;
          if (idx_q != 16'hFFFF) idx_nxt = idx_q + 16'd1;
        end
      end
      FINISH: begin
`ifdef DSM_SWEEP_LOOP_EN
        state_nxt = ISSUE;
        tdata_nxt = start_q;
        idx_nxt   = '0;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      tdata_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      inc_q    <= '0;
      dwell_q  <= '0;
      dither_q <= 1'b0;
    end else begin
      tdata_q <= tdata_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      if (load_cfg) begin
        start_q  <= cfg_start_step;
        stop_q   <= cfg_stop_step;
        inc_q    <= cfg_step_inc;
        dwell_q  <= cfg_dwell;
        dither_q <= cfg_dither;
      end
    end
  end

  assign m_axis_step.tdata  = tdata_q;
  assign m_axis_step.tvalid = (state == ISSUE);
  assign done               = (state == FINISH);
`ifdef DSM_SWEEP_LOOP_EN
  assign busy               = (state != IDLE);
`else
  assign busy               = (state == ISSUE) || (state == DWELL);
`endif
  assign dither_enable      = busy & dither_q;
  assign point_idx          = idx_q;

endmodule

// File: tb/tb_dsm_sweep_ctrl.sv
// Bench for dsm_sweep_ctrl: directed table, abort/reset corner cases, randomized sweeps vs a point-list model.
module tb_dsm_sweep_ctrl;

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_start_step = '0;
  logic [31:0] cfg_stop_step = '0;
  logic [31:0] cfg_step_inc = '0;
  logic [23:0] cfg_dwell = '0;
  logic        cfg_dither = 1'b0;
  logic        dither_enable, busy, done;
  logic [15:0] point_idx;

  dsm_sweep_ctrl_if #(.STEP_WIDTH(32)) step_if ();

  dsm_sweep_ctrl #(.STEP_WIDTH(32), .DWELL_WIDTH(24)) dut (
    .aclk          (aclk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_start_step(cfg_start_step),
    .cfg_stop_step (cfg_stop_step),
    .cfg_step_inc  (cfg_step_inc),
    .cfg_dwell     (cfg_dwell),
    .cfg_dither    (cfg_dither),
    .m_axis_step   (step_if),
    .dither_enable (dither_enable),
    .busy          (busy),
    .done          (done),
    .point_idx     (point_idx)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] s, e, inc;
    logic [23:0] dw;
    bit          dith;
    int          mode;      // 0: tready high, 1: random tready + stray starts, 2: 7-cycle stall on point index 1
    int          exp_n;
    logic [31:0] exp_last;
  } vec_t;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_out(input string nm, input bit ev, input bit eb, input bit ed, input bit edi,
                         input logic [15:0] ei, input logic [31:0] et, input bit use_t);
    logic [51:0] got, exp;
    got = {step_if.tvalid, busy, done, dither_enable, point_idx, use_t ? step_if.tdata : 32'h0};
    exp = {ev, eb, ed, edi, ei, use_t ? et : 32'h0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got tvalid=%0b busy=%0b done=%0b dith=%0b idx=%0d tdata=%h, expected tvalid=%0b busy=%0b done=%0b dith=%0b idx=%0d tdata=%h",
               nm, step_if.tvalid, busy, done, dither_enable, point_idx, step_if.tdata,
               ev, eb, ed, edi, ei, use_t ? et : step_if.tdata);
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Expected point list straight from the sweep rules, using wide arithmetic for the carry case.
  task automatic build_model(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc);
    longint unsigned cur;
    exp_q.delete();
    exp_q.push_back(s);
    if (inc != 0 && s < e) begin
      cur = longint'(s);
      while (cur != longint'(e)) begin
        cur = cur + longint'(inc);
        if (cur >= longint'(e)) cur = longint'(e);
        exp_q.push_back(cur[31:0]);
      end
    end
  endtask

  task automatic scramble_cfg();
    cfg_start_step = $urandom;
    cfg_stop_step  = $urandom;
    cfg_step_inc   = $urandom;
    cfg_dwell      = 24'($urandom);
    cfg_dither     = 1'($urandom_range(0, 1));
  endtask

  task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                           input logic [23:0] dw, input bit dith, input int mode, input string nm,
                           output logic [15:0] fin_idx, output logic [31:0] fin_data);
    int dwl, n, last;
    bit acc;
    build_model(s, e, inc);
    dwl  = (dw == 0) ? 1 : int'(dw);
    last = exp_q.size() - 1;
    cfg_start_step = s; cfg_stop_step = e; cfg_step_inc = inc; cfg_dwell = dw; cfg_dither = dith;
    start = 1'b1;
    step();
    start = 1'b0;
    scramble_cfg();
    fin_idx = '0;
    fin_data = '0;
    for (int k = 0; k < exp_q.size(); k++) begin
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        case (mode)
          0:       step_if.tready = 1'b1;
          1:       step_if.tready = 1'($urandom_range(0, 1));
          default: step_if.tready = (k == 1 && n < 7) ? 1'b0 : 1'b1;
        endcase
        if (mode == 1) begin
          start = 1'($urandom_range(0, 1));
          scramble_cfg();
        end
        @(negedge aclk);
        chk_out({nm, "_issue"}, 1'b1, 1'b1, 1'b0, dith, 16'(k), exp_q[k], 1'b1);
        acc = step_if.tready;
        step();
        n++;
        if (!acc && n >= 200) begin
          checks++;
          errors++;
          $display("FAIL %s_timeout: tready never accepted after %0d cycles", nm, n);
          start = 1'b0;
          return;
        end
      end
      for (int d = 0; d < dwl; d++) begin
        if (mode == 1) begin
          start = 1'($urandom_range(0, 1));
          step_if.tready = 1'($urandom_range(0, 1));
        end
        @(negedge aclk);
        chk_out({nm, "_dwell"}, 1'b0, 1'b1, 1'b0, dith, 16'(k), exp_q[k], 1'b1);
        step();
      end
    end
    start = 1'b0;
    @(negedge aclk);
    fin_idx  = point_idx;
    fin_data = step_if.tdata;
`ifdef DSM_SWEEP_LOOP_EN
    chk_out({nm, "_finish"}, 1'b0, 1'b1, 1'b1, dith, 16'(last), exp_q[last], 1'b1);
    step_if.tready = 1'b0;
    step();
    @(negedge aclk);
    chk_out({nm, "_reissue"}, 1'b1, 1'b1, 1'b0, dith, 16'd0, exp_q[0], 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge aclk);
    chk_out({nm, "_loop_abort"}, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0);
    step();
`else
    chk_out({nm, "_finish"}, 1'b0, 1'b0, 1'b1, 1'b0, 16'(last), exp_q[last], 1'b1);
    step();
    @(negedge aclk);
    chk_out({nm, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 16'(last), exp_q[last], 1'b1);
    step();
`endif
  endtask

  task automatic load_row0(input bit dith);
    cfg_start_step = 32'h100; cfg_stop_step = 32'h400; cfg_step_inc = 32'h100;
    cfg_dwell = 24'd4; cfg_dither = dith;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[9];
    logic [15:0] fi;
    logic [31:0] fd, rs, re, rinc;
    logic [23:0] rdw;
    bit          rdith;

    tbl[0] = '{32'h100,      32'h400,      32'h100, 24'd4, 1'b0, 0, 4, 32'h400};
    tbl[1] = '{32'h100,      32'h350,      32'h100, 24'd4, 1'b0, 0, 4, 32'h350};
    tbl[2] = '{32'h100,      32'h400,      32'h100, 24'd4, 1'b0, 2, 4, 32'h400};
    tbl[3] = '{32'h100,      32'h400,      32'h0,   24'd4, 1'b0, 0, 1, 32'h100};
    tbl[4] = '{32'h500,      32'h400,      32'h100, 24'd3, 1'b0, 0, 1, 32'h500};
    tbl[5] = '{32'hFFFFFF00, 32'hFFFFFFFF, 32'h200, 24'd2, 1'b0, 0, 2, 32'hFFFFFFFF};
    tbl[6] = '{32'h10,       32'h30,       32'h10,  24'd0, 1'b0, 0, 3, 32'h30};
    tbl[7] = '{32'h100,      32'h400,      32'h100, 24'd4, 1'b1, 1, 4, 32'h400};
    tbl[8] = '{32'h200,      32'h200,      32'h10,  24'd2, 1'b0, 0, 1, 32'h200};

    step_if.tready = 1'b0;
    rst = 1'b1;
    cfg_dither = 1'b1;
    repeat (3) step();
    @(negedge aclk);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b1);
    rst = 1'b0;
    step();
    @(negedge aclk);
    chk_out("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b1);
    step();

    for (int i = 0; i < 9; i++) begin
      run_sweep(tbl[i].s, tbl[i].e, tbl[i].inc, tbl[i].dw, tbl[i].dith, tbl[i].mode, $sformatf("tbl%0d", i), fi, fd);
      chk_val($sformatf("tbl%0d_last_step", i), fd, tbl[i].exp_last);
      chk_val($sformatf("tbl%0d_last_idx", i), {16'h0, fi}, 32'(tbl[i].exp_n - 1));
    end

    // Abort in the middle of point 0's dwell.
    load_row0(1'b1);
    step_if.tready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    @(negedge aclk);
    chk_out("abortA_pre", 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 32'h100, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge aclk);
    chk_out("abortA_idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0);
    repeat (6) step();
    @(negedge aclk);
    chk_out("abortA_quiet", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0);
    step();

    // Abort while the step word is stalled by tready.
    step_if.tready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    @(negedge aclk);
    chk_out("abortB_pre", 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 32'h100, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge aclk);
    chk_out("abortB_idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0);
    step();

    // Abort and start together: abort wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge aclk);
    chk_out("abort_beats_start", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0);
    step();
    @(negedge aclk);
    chk_out("abort_beats_start_hold", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b0);
    step();

    // Reset in the middle of a sweep.
    step_if.tready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge aclk);
    chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b1);
    step();
    @(negedge aclk);
    chk_out("rst_mid_no_done", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'h0, 1'b1);
    step();

    run_sweep(32'h100, 32'h400, 32'h100, 24'd4, 1'b1, 0, "restart", fi, fd);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        rs   = 32'hFFFFFF00 + $urandom_range(0, 127);
        re   = 32'hFFFFFF80 + $urandom_range(0, 127);
        rinc = $urandom_range(64, 512);
      end else begin
        rs   = $urandom_range(0, 200);
        re   = $urandom_range(0, 600);
        rinc = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom_range(16, 120);
      end
      rdw   = 24'($urandom_range(0, 5));
      rdith = 1'($urandom_range(0, 1));
      run_sweep(rs, re, rinc, rdw, rdith, 1, $sformatf("rand%0d", r), fi, fd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
